hilo_ctrl: RTL and testbench

- Sequencing controller for the HI/LO result register pair of the multiply/divide path.
- Accepts mult/div issue requests from the pipeline, launches the fixed-latency mul/div unit, and counts its latency.
- Arbitrates writes into the HI and LO generic registers between MTHI/MTLO and unit results.
- Stalls the pipeline on any HI/LO access made while an operation is in flight.

---
 rtl/hilo_ctrl.sv | 119 +++++++++++
 tb/tb_hilo_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/hilo_ctrl.sv
// ---------------------------------------------------------------------------
// hilo_ctrl - sequencing controller for the HI/LO result register pair.
//
// It accepts mult/div issue requests, launches the fixed-latency mul/div
// unit, and counts the unit's latency. It arbitrates HI/LO register writes
// between MTHI/MTLO moves and unit results. It also stalls the pipeline on
// any HI/LO access made while an operation is in flight.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   op_start, op_type     issue request; op_type: 00 multu 01 mult 10 divu 11 div
//   mtlo_en, mthi_en      move-to-LO / move-to-HI write requests
//   mt_data               data for MTLO/MTHI
//   mf_req                MFLO/MFHI read request (only used for stalling)
//   unit_lo, unit_hi      unit results (low/quotient, high/remainder)
//   unit_start            one-cycle registered launch pulse to the unit
//   unit_sign             signed op, held for the whole op
//   unit_is_div           divide op, held for the whole op
//   lo_en/lo_d, hi_en/hi_d  HI/LO register write enables and data
//   busy                  operation in flight
//   stall                 pipeline stall
// ---------------------------------------------------------------------------
module hilo_ctrl #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CW      = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_start,
    input  logic [1:0]       op_type,
    input  logic             mtlo_en,
    input  logic             mthi_en,
    input  logic [WIDTH-1:0] mt_data,
    input  logic             mf_req,
    input  logic [WIDTH-1:0] unit_lo,
    input  logic [WIDTH-1:0] unit_hi,
    output logic             unit_start,
    output logic             unit_sign,
    output logic             unit_is_div,
    output logic             lo_en,
    output logic             hi_en,
    output logic [WIDTH-1:0] lo_d,
    output logic [WIDTH-1:0] hi_d,
    output logic             busy,
    output logic             stall
);

    typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

    // The counter is loaded with LAT-1 so that RUN lasts exactly LAT cycles
    // (the count==0 cycle is the last RUN cycle).
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

    state_t        state, state_nx;
    logic [CW-1:0] count, count_nx;
    logic          launch;

    // A launch is only accepted from IDLE; op_start while busy is stalled.
    assign launch = (state == IDLE) && op_start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            unit_start  <= 1'b0;
            unit_sign   <= 1'b0;
            unit_is_div <= 1'b0;
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            unit_start <= launch;
            // Op attributes stay frozen from launch until the next launch.
            if (launch) begin
                unit_sign   <= op_type[0];
                unit_is_div <= op_type[1];
            end
        end
    end

    always_comb begin
        state_nx = state;
        count_nx = count;
        lo_en    = 1'b0;
        hi_en    = 1'b0;
        lo_d     = mt_data;
        hi_d     = mt_data;
        case (state)
            IDLE: begin
                // Moves write immediately, even alongside a launch; the
                // op result overwrites both registers later.
                lo_en = mtlo_en;
                hi_en = mthi_en;
                if (op_start) begin
                    state_nx = RUN;
                    count_nx = op_type[1] ? DIV_LOAD : MUL_LOAD;
                end
            end
            RUN: begin
                if (count == '0) state_nx = WB;
                else             count_nx = count - 1'b1;
            end
            WB: begin
                lo_en    = 1'b1;
                hi_en    = 1'b1;
                lo_d     = unit_lo;
                hi_d     = unit_hi;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy  = (state != IDLE);
    assign stall = busy & (op_start | mf_req | mtlo_en | mthi_en);

endmodule

// File: tb/tb_hilo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hilo_ctrl - directed self-checking bench for hilo_ctrl.
// Register writes are predicted into a scoreboard queue when stimulus is
// driven (with the cycle they must appear in) and popped by a monitor that
// samples on the falling edge whenever lo_en or hi_en is high.
// ---------------------------------------------------------------------------
module tb_hilo_ctrl;
    localparam int WIDTH = 32;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             op_start = 1'b0;
    logic [1:0]       op_type = 2'b00;
    logic             mtlo_en = 1'b0;
    logic             mthi_en = 1'b0;
    logic [WIDTH-1:0] mt_data = '0;
    logic             mf_req = 1'b0;
    logic [WIDTH-1:0] unit_lo = '0;
    logic [WIDTH-1:0] unit_hi = '0;
    logic             unit_start, unit_sign, unit_is_div;
    logic             lo_en, hi_en, busy, stall;
    logic [WIDTH-1:0] lo_d, hi_d;

    hilo_ctrl #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CW(6)) dut (
        .clk(clk), .reset(reset), .op_start(op_start), .op_type(op_type),
        .mtlo_en(mtlo_en), .mthi_en(mthi_en), .mt_data(mt_data), .mf_req(mf_req),
        .unit_lo(unit_lo), .unit_hi(unit_hi), .unit_start(unit_start),
        .unit_sign(unit_sign), .unit_is_div(unit_is_div), .lo_en(lo_en),
        .hi_en(hi_en), .lo_d(lo_d), .hi_d(hi_d), .busy(busy), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               cyc;
        logic             lo_en;
        logic             hi_en;
        logic [WIDTH-1:0] lo_d;
        logic [WIDTH-1:0] hi_d;
    } wr_t;

    wr_t sb[$];
    int  cyc = 0;
    int  n_chk = 0;
    int  n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic le, input logic he,
                        input logic [WIDTH-1:0] ld, input logic [WIDTH-1:0] hd);
        wr_t w;
        w.cyc = c; w.lo_en = le; w.hi_en = he; w.lo_d = ld; w.hi_d = hd;
        sb.push_back(w);
    endtask

    // Monitor: every register write must match the next predicted write.
    always @(negedge clk) begin
        if (!reset && (lo_en || hi_en)) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {62'd0, lo_en, hi_en}, 64'd0);
            end else begin
                wr_t w;
                w = sb.pop_front();
                chk("wr_cycle", 64'(cyc), 64'(w.cyc));
                chk("wr_en", {62'd0, lo_en, hi_en}, {62'd0, w.lo_en, w.hi_en});
                if (w.lo_en) chk("wr_lo_d", 64'(lo_d), 64'(w.lo_d));
                if (w.hi_en) chk("wr_hi_d", 64'(hi_d), 64'(w.hi_d));
            end
        end
    end

    int t0;

    initial begin
        // ---- reset, then idle
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_unit_start", 64'(unit_start), 64'd0);
        chk("rst_sign", 64'(unit_sign), 64'd0);
        chk("rst_is_div", 64'(unit_is_div), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_flags", {59'd0, busy, unit_start, lo_en, hi_en, stall}, 64'd0);
        end

        // ---- signed mult
        unit_lo = 32'h0000_0006; unit_hi = 32'h0;
        op_start = 1'b1; op_type = 2'b01; t0 = cyc;
        push(t0 + MUL_LAT + 1, 1'b1, 1'b1, 32'h6, 32'h0);
        chk("mul_T_stall", 64'(stall), 64'd0);
        tick(); op_start = 1'b0;
        chk("mul_T1_start", {61'd0, unit_start, unit_sign, unit_is_div}, 64'b110);
        chk("mul_T1_busy", 64'(busy), 64'd1);
        for (int i = 2; i <= MUL_LAT + 1; i++) begin
            tick();
            chk("mul_run_flags", {62'd0, busy, unit_start}, 64'b10);
        end
        tick();
        chk("mul_done_busy", 64'(busy), 64'd0);

        // ---- unsigned divide
        unit_lo = 32'h0000_0011; unit_hi = 32'h0000_0022;
        op_start = 1'b1; op_type = 2'b10; t0 = cyc;
        push(t0 + DIV_LAT + 1, 1'b1, 1'b1, 32'h11, 32'h22);
        tick(); op_start = 1'b0;
        chk("div_T1_start", {61'd0, unit_start, unit_sign, unit_is_div}, 64'b101);
        for (int i = 2; i <= DIV_LAT + 1; i++) begin
            tick();
            chk("div_busy", {62'd0, busy, unit_is_div}, 64'b11);
        end
        tick();
        chk("div_done_busy", 64'(busy), 64'd0);

        // ---- move + read held during a multu: stalled until IDLE
        unit_lo = 32'hA5A5_0001; unit_hi = 32'h5A5A_0002;
        op_start = 1'b1; op_type = 2'b00; t0 = cyc;
        push(t0 + MUL_LAT + 1, 1'b1, 1'b1, 32'hA5A5_0001, 32'h5A5A_0002);
        push(t0 + MUL_LAT + 2, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        tick(); op_start = 1'b0;
        chk("mulu_sign", 64'(unit_sign), 64'd0);
        tick();
        mf_req = 1'b1; mtlo_en = 1'b1; mt_data = 32'hDEAD_BEEF;
        #1;
        for (int i = 2; i <= MUL_LAT + 1; i++) begin
            chk("held_stall", 64'(stall), 64'd1);
            tick();
        end
        chk("idle_stall", 64'(stall), 64'd0);
        chk("idle_lo_en", 64'(lo_en), 64'd1);
        tick();
        mf_req = 1'b0; mtlo_en = 1'b0;

        // ---- launch and MTHI in the same IDLE cycle
        unit_lo = 32'h0000_7777; unit_hi = 32'h0000_8888;
        op_start = 1'b1; op_type = 2'b01; mthi_en = 1'b1; mt_data = 32'h0000_1234;
        t0 = cyc;
        push(t0, 1'b0, 1'b1, 32'h1234, 32'h1234);
        push(t0 + MUL_LAT + 1, 1'b1, 1'b1, 32'h7777, 32'h8888);
        #1;
        chk("combo_stall", 64'(stall), 64'd0);
        tick(); op_start = 1'b0; mthi_en = 1'b0;
        chk("combo_launch", {62'd0, unit_start, busy}, 64'b11);
        for (int i = 0; i < MUL_LAT + 2; i++) tick();

        // ---- reset mid-divide aborts the op
        unit_lo = 32'hBAD0_0001; unit_hi = 32'hBAD0_0002;
        op_start = 1'b1; op_type = 2'b11; t0 = cyc;
        tick(); op_start = 1'b0;
        chk("sdiv_T1", {61'd0, unit_start, unit_sign, unit_is_div}, 64'b111);
        tick(); tick();
        reset = 1'b1;
        tick(); reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_is_div", 64'(unit_is_div), 64'd0);
        for (int i = 0; i < DIV_LAT + 4; i++) begin
            tick();
            chk("abort_idle", {62'd0, busy, unit_start}, 64'd0);
        end

        // ---- new op after abort
        unit_lo = 32'h0000_00AB; unit_hi = 32'h0000_00CD;
        op_start = 1'b1; op_type = 2'b01; t0 = cyc;
        push(t0 + MUL_LAT + 1, 1'b1, 1'b1, 32'hAB, 32'hCD);
        tick(); op_start = 1'b0;
        chk("post_abort_start", {62'd0, unit_start, busy}, 64'b11);
        for (int i = 0; i < MUL_LAT + 3; i++) tick();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
